// File: rtl/layer_pingpong_buffer.sv
// layer_pingpong_buffer: double-buffered feature store between the feature
// AXI-Stream and the MAC array. Packs IN_W beats into WORD_W words, fills one
// bank while the other is replayed cfg_passes times through a 2-entry skid FIFO.
module layer_pingpong_buffer #(
    parameter int IN_W   = 32,
    parameter int BPW    = 7,
    parameter int DEPTH  = 64,
    parameter int PASS_W = 3,
    parameter int WORD_W = IN_W * BPW,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [IN_W-1:0]   in_TDATA,
    input  logic              in_TVALID,
    output logic              in_TREADY,
    input  logic              in_TLAST,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic [WORD_W-1:0] out_TDATA,
    output logic              out_TVALID,
    input  logic              out_TREADY,
    output logic              out_TLAST,
    output logic [PASS_W-1:0] out_pass,
    output logic [1:0]        bank_full
);
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;

    // Both banks share one array; the bank index is the address MSB.
    logic [WORD_W-1:0] mem [2*DEPTH];
    logic [WORD_W-1:0] ram_rdata_q;

    // Write side
    logic              wr_bank_q, wr_bank_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic [WORD_W-1:0] pack_q, pack_d, wr_word;
    logic              in_tready_q, in_tready_d;
    logic              in_acc, word_done, bank_close;
    logic [1:0]        full_q, full_d;
    logic [AW:0]       len_q [2];
    logic [AW:0]       len_d [2];

    // Read side
    rd_state_t         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [PASS_W-1:0] pass_q, pass_d, passes_q, passes_d;
    logic              rd_en, rd_is_last;
    logic              rd_vld_q, rd_last_q;
    logic [PASS_W-1:0] rd_pass_q;
    logic [2:0]        credit;

    // Output skid FIFO
    logic [WORD_W-1:0] fdata_q [2];
    logic [WORD_W-1:0] fdata_d [2];
    logic [PASS_W-1:0] fpass_q [2];
    logic [PASS_W-1:0] fpass_d [2];
    logic [1:0]        flast_q, flast_d;
    logic              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push, pop;

    // Packer: slot the accepted beat into the word; emit on the BPW-th or TLAST beat.
    always_comb begin
        in_acc     = in_TVALID & in_tready_q;
        wr_word    = pack_q | (WORD_W'(in_TDATA) << (int'(beat_q) * IN_W));
        word_done  = in_acc & ((beat_q == BC_W'(BPW - 1)) | in_TLAST);
        bank_close = word_done & ((wr_addr_q == AW'(DEPTH - 1)) | in_TLAST);
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        beat_d     = beat_q;
        pack_d     = pack_q;
        if (word_done) begin
            pack_d    = '0;
            beat_d    = '0;
            wr_addr_d = bank_close ? '0 : wr_addr_q + AW'(1);
            wr_bank_d = bank_close ? ~wr_bank_q : wr_bank_q;
        end else if (in_acc) begin
            pack_d = wr_word;
            beat_d = beat_q + BC_W'(1);
        end
    end

    // Bank flags and read sequencing; writer close and reader free may coincide on different banks.
    always_comb begin
        full_d     = full_q;
        len_d      = len_q;
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_addr_d  = rd_addr_q;
        pass_d     = pass_q;
        passes_d   = passes_q;
        rd_en      = 1'b0;
        pop        = (cnt_q != 2'd0) & out_TREADY;
        credit     = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
        rd_is_last = ({1'b0, rd_addr_q} == len_q[rd_bank_q] - (AW+1)'(1));
        if (bank_close) begin
            full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]  = {1'b0, wr_addr_q} + (AW+1)'(1);
        end
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    passes_d  = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
                    pass_d    = '0;
                    rd_addr_d = '0;
                    state_d   = RD_READ;
                end
            end
            RD_READ: begin
                if (credit < 3'd2) begin
                    rd_en = 1'b1;
                    if (rd_is_last) begin
                        rd_addr_d = '0;
                        if (pass_q < passes_q - PASS_W'(1)) pass_d = pass_q + PASS_W'(1);
                        else state_d = RD_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            RD_DRAIN: begin
                // Nothing in flight and the FIFO empties this cycle: last word accepted.
                if (credit == 3'd0) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        in_tready_d = ~full_d[wr_bank_d];
    end

    // Skid FIFO bookkeeping; a RAM result always has a free slot thanks to the read credit.
    always_comb begin
        push    = rd_vld_q;
        fdata_d = fdata_q;
        fpass_d = fpass_q;
        flast_d = flast_q;
        wptr_d  = wptr_q;
        rptr_d  = pop ? ~rptr_q : rptr_q;
        if (push) begin
            fdata_d[wptr_q] = ram_rdata_q;
            fpass_d[wptr_q] = rd_pass_q;
            flast_d[wptr_q] = rd_last_q;
            wptr_d          = ~wptr_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    // Feature RAM: one write port from the packer, one registered read port.
    always_ff @(posedge ap_clk) begin
        if (word_done) mem[{wr_bank_q, wr_addr_q}] <= wr_word;
        ram_rdata_q <= mem[{rd_bank_q, rd_addr_q}];
    end

    // State registers; reset clears flags, packer, read pipeline and FIFO contents.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            beat_q      <= '0;
            pack_q      <= '0;
            in_tready_q <= 1'b0;
            full_q      <= '0;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            state_q     <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            pass_q      <= '0;
            passes_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_pass_q   <= '0;
            fdata_q[0]  <= '0;
            fdata_q[1]  <= '0;
            fpass_q[0]  <= '0;
            fpass_q[1]  <= '0;
            flast_q     <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            beat_q      <= beat_d;
            pack_q      <= pack_d;
            in_tready_q <= in_tready_d;
            full_q      <= full_d;
            len_q       <= len_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            pass_q      <= pass_d;
            passes_q    <= passes_d;
            rd_vld_q    <= rd_en;
            rd_last_q   <= rd_is_last;
            rd_pass_q   <= pass_q;
            fdata_q     <= fdata_d;
            fpass_q     <= fpass_d;
            flast_q     <= flast_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_TREADY  = in_tready_q;
    assign out_TVALID = (cnt_q != 2'd0);
    assign out_TDATA  = fdata_q[rptr_q];
    assign out_TLAST  = flast_q[rptr_q];
    assign out_pass   = fpass_q[rptr_q];
    assign bank_full  = full_q;

endmodule

// File: tb/tb_layer_pingpong_buffer.sv
// Testbench for layer_pingpong_buffer: directed phases with randomized data and
// handshakes, checked against a bank-level model of the expected word stream.
module tb_layer_pingpong_buffer;
    localparam int IN_W = 32, BPW = 7, DEPTH = 64, PASS_W = 3;
    localparam int WORD_W = IN_W * BPW;
    localparam int BANK_BEATS = BPW * DEPTH;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [IN_W-1:0]   in_TDATA;
    logic              in_TVALID, in_TREADY, in_TLAST;
    logic [PASS_W-1:0] cfg_passes;
    logic [WORD_W-1:0] out_TDATA;
    logic              out_TVALID, out_TREADY, out_TLAST;
    logic [PASS_W-1:0] out_pass;
    logic [1:0]        bank_full;

    always #5 ap_clk = ~ap_clk;

    layer_pingpong_buffer #(.IN_W(IN_W), .BPW(BPW), .DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TLAST(in_TLAST),
        .cfg_passes(cfg_passes),
        .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
        .out_TLAST(out_TLAST), .out_pass(out_pass), .bank_full(bank_full)
    );

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic              l;
        logic [PASS_W-1:0] p;
    } exp_t;

    exp_t              exp_q[$];
    logic [IN_W:0]     pend_q[$];
    logic [IN_W-1:0]   bank_beats[$];
    int checks = 0, errors = 0, cyc = 0;
    int in_pct = 100, rdy_pct = 100;
    bit in_acc = 1'b0, stall_prev = 1'b0;
    exp_t prev_out;
    int hs_cnt, first_hs_cyc, last_hs_cyc, first_valid_cyc, close_edge, close_cnt;
    int beats_acc, max_pass, last_hs_pass;
    logic [WORD_W-1:0] first_word, last_word;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; first_hs_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1;
        close_edge = 0; close_cnt = 0; beats_acc = 0; max_pass = -1; last_hs_pass = -1;
    endtask

    // A closed bank becomes its word list replayed once per pass.
    task automatic close_bank();
        int n, np;
        logic [WORD_W-1:0] words[$];
        logic [WORD_W-1:0] word;
        exp_t e;
        n  = (bank_beats.size() + BPW - 1) / BPW;
        np = (cfg_passes == 0) ? 1 : int'(cfg_passes);
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int b = 0; b < BPW; b++)
                if (w * BPW + b < bank_beats.size())
                    word = word | (WORD_W'(bank_beats[w * BPW + b]) << (b * IN_W));
            words.push_back(word);
        end
        for (int p = 0; p < np; p++)
            for (int w = 0; w < n; w++) begin
                e.d = words[w]; e.l = (w == n - 1); e.p = PASS_W'(p);
                exp_q.push_back(e);
            end
        bank_beats.delete();
        close_cnt++;
        if (close_cnt == 1) close_edge = cyc + 1;
    endtask

    task automatic model_beat(input logic [IN_W:0] bt);
        bank_beats.push_back(bt[IN_W-1:0]);
        beats_acc++;
        if (bt[IN_W] || bank_beats.size() == BANK_BEATS) close_bank();
    endtask

    // One clock: drive at negedge, score handshakes that the next edge completes.
    task automatic cycle();
        exp_t cur, e;
        @(negedge ap_clk);
        if (in_acc) begin in_TVALID = 1'b0; in_TLAST = 1'b0; in_acc = 1'b0; end
        if (ap_rst) begin
            in_TVALID = 1'b0; in_TLAST = 1'b0; out_TREADY = 1'b0;
        end else begin
            if (!in_TVALID && pend_q.size() != 0 && $urandom_range(99) < in_pct) begin
                in_TVALID = 1'b1;
                in_TLAST  = pend_q[0][IN_W];
                in_TDATA  = pend_q[0][IN_W-1:0];
            end
            out_TREADY = ($urandom_range(99) < rdy_pct);
        end
        cur.d = out_TDATA; cur.l = out_TLAST; cur.p = out_pass;
        if (stall_prev) begin
            chk("valid_held", out_TVALID, 1);
            chk("stable_while_stalled", cur, prev_out);
        end
        if (!ap_rst) begin
            if (out_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_TVALID && out_TREADY) begin
                if (exp_q.size() == 0) chk("unexpected_valid", out_TVALID, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_word", cur, e);
                end
                if (hs_cnt == 0) first_word = cur.d;
                last_word = cur.d;
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (int'(out_pass) > max_pass) max_pass = int'(out_pass);
                last_hs_pass = int'(out_pass);
            end
            if (in_TVALID && in_TREADY) begin
                in_acc = 1'b1;
                model_beat(pend_q.pop_front());
            end
            stall_prev = out_TVALID && !out_TREADY;
            prev_out   = cur;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic run_drain(input int max, input string tag);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0 || in_TVALID) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, (pend_q.size() == 0 && exp_q.size() == 0), 1);
        repeat (4) cycle();
    endtask

    task automatic push_bank(input int n, input bit last, input bit ramp);
        for (int k = 0; k < n; k++)
            pend_q.push_back({(last && k == n - 1), ramp ? IN_W'(k) : IN_W'($urandom)});
    endtask

    initial begin
        logic [WORD_W-1:0] w0;
        int i, total, rl;
        ap_rst = 1'b1; in_TVALID = 1'b0; in_TDATA = '0; in_TLAST = 1'b0;
        out_TREADY = 1'b0; cfg_passes = 3'd1;
        clear_stats();

        // Reset state
        repeat (3) cycle();
        chk("rst_in_tready", in_TREADY, 0);
        chk("rst_out_tvalid", out_TVALID, 0);
        chk("rst_out_tlast", out_TLAST, 0);
        chk("rst_out_pass", out_pass, 0);
        chk("rst_out_tdata", out_TDATA, 0);
        chk("rst_bank_full", bank_full, 0);
        ap_rst = 1'b0;
        cycle();
        chk("tready_after_reset", in_TREADY, 1);

        // Full bank, ramp data, 4 passes, ready held high
        cfg_passes = 3'd4; in_pct = 100; rdy_pct = 100; clear_stats();
        push_bank(BANK_BEATS, 1'b0, 1'b1);
        run_drain(3000, "fill_done");
        w0 = '0;
        for (int k = 0; k < BPW; k++) w0 = w0 | (WORD_W'(k) << (k * IN_W));
        chk("fill_word_count", hs_cnt, 256);
        chk("fill_word0", first_word, w0);
        chk("fill_latency", first_valid_cyc - close_edge, 3);
        chk("fill_throughput", last_hs_cyc - first_hs_cyc, 255);
        chk("fill_last_pass", max_pass, 3);
        chk("fill_bank_freed", bank_full, 0);

        // Early close on TLAST
        cfg_passes = 3'd1; clear_stats();
        push_bank(10, 1'b1, 1'b0);
        run_drain(200, "early_done");
        chk("early_word_count", hs_cnt, 2);
        chk("early_upper_zero", last_word >> (3 * IN_W), 0);

        // Ping-pong stall: three full banks against a stalled output
        cfg_passes = 3'd1; rdy_pct = 0; clear_stats();
        for (int b = 0; b < 3; b++) push_bank(BANK_BEATS, 1'b0, 1'b0);
        repeat (1000) cycle();
        chk("pp_both_full", bank_full, 2'b11);
        chk("pp_in_tready_low", in_TREADY, 0);
        chk("pp_beats_taken", beats_acc, 2 * BANK_BEATS);
        chk("pp_out_valid", out_TVALID, 1);
        rdy_pct = 100;
        i = 0;
        while (bank_full == 2'b11 && i < 400) begin cycle(); i++; end
        chk("pp_bank0_freed", bank_full, 2'b10);
        chk("pp_in_tready_back", in_TREADY, 1);
        chk("pp_bank0_drained", exp_q.size(), 64);
        run_drain(5000, "pp_done");
        chk("pp_word_count", hs_cnt, 3 * 64);
        chk("pp_bank_freed", bank_full, 0);

        // Random backpressure, 2 passes, four banks of assorted shapes
        cfg_passes = 3'd2; in_pct = 70; rdy_pct = 30; clear_stats();
        rl = $urandom_range(BANK_BEATS - 1, 2);
        push_bank(BANK_BEATS, 1'b0, 1'b0);
        push_bank(BANK_BEATS, 1'b1, 1'b0);
        push_bank(1, 1'b1, 1'b0);
        push_bank(rl, 1'b1, 1'b0);
        total = 2 * (64 + 64 + 1 + (rl + BPW - 1) / BPW);
        run_drain(30000, "rand_done");
        chk("rand_word_count", hs_cnt, total);
        chk("rand_bank_freed", bank_full, 0);

        // Reset during pass 1
        cfg_passes = 3'd3; in_pct = 100; rdy_pct = 100; clear_stats();
        push_bank(BANK_BEATS, 1'b0, 1'b0);
        i = 0;
        while (last_hs_pass != 1 && i < 2000) begin cycle(); i++; end
        chk("rst_reached_pass1", last_hs_pass, 1);
        ap_rst = 1'b1;
        cycle();
        chk("midrst_out_tvalid", out_TVALID, 0);
        chk("midrst_bank_full", bank_full, 0);
        chk("midrst_in_tready", in_TREADY, 0);
        exp_q.delete(); pend_q.delete(); bank_beats.delete();
        ap_rst = 1'b0;
        cycle();
        chk("midrst_tready_back", in_TREADY, 1);
        cfg_passes = 3'd1; clear_stats();
        push_bank(20, 1'b1, 1'b0);
        run_drain(300, "midrst_done");
        chk("midrst_word_count", hs_cnt, 3);

        // cfg_passes extremes
        cfg_passes = 3'd0; clear_stats();
        push_bank(5, 1'b1, 1'b0);
        run_drain(200, "pass0_done");
        chk("pass0_word_count", hs_cnt, 1);
        chk("pass0_max_pass", max_pass, 0);
        cfg_passes = 3'd7; clear_stats();
        push_bank(10, 1'b1, 1'b0);
        run_drain(400, "pass7_done");
        chk("pass7_word_count", hs_cnt, 14);
        chk("pass7_max_pass", max_pass, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
